// File: rtl/sseg_pkg.sv
// Shared constants and types for the eight-digit seven-segment scan controller.
package sseg_pkg;

    localparam int         NUM_DIGITS = 8;
    localparam logic [7:0] BLANK      = 8'hFF;

    typedef logic [2:0] digit_idx_t;

    typedef struct packed {
        logic [31:0] hex;
        logic [7:0]  dp;
        logic [7:0]  en;
    } disp_data_t;

endpackage

// File: rtl/sseg_scan_ctrl_dec.sv
// Hex nibble to active-low segment decoder, output {dp,g,f,e,d,c,b,a}.
module sseg_scan_ctrl_dec (
    input  logic [3:0] nibble,
    input  logic       dp_n,
    output logic [7:0] seg
);

    logic [6:0] seg_lo;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        seg_lo = 7'h7F;
        case (nibble)
            4'h0: seg_lo = 7'h40;
            4'h1: seg_lo = 7'h79;
            4'h2: seg_lo = 7'h24;
            4'h3: seg_lo = 7'h30;
            4'h4: seg_lo = 7'h19;
            4'h5: seg_lo = 7'h12;
            4'h6: seg_lo = 7'h02;
            4'h7: seg_lo = 7'h78;
            4'h8: seg_lo = 7'h00;
            4'h9: seg_lo = 7'h10;
            4'hA: seg_lo = 7'h08;
            4'hB: seg_lo = 7'h03;
            4'hC: seg_lo = 7'h46;
            4'hD: seg_lo = 7'h21;
            4'hE: seg_lo = 7'h06;
            4'hF: seg_lo = 7'h0E;
            default: seg_lo = 7'h7F;
        endcase
    end

    assign seg = {dp_n, seg_lo};

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scanner with frame-synchronous, tear-free updates.
// Optional PWM dimming is enabled by defining SSEG_DIM_EN (adds the brightness input).
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic [31:0] hex_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  digit_en,
`ifdef SSEG_DIM_EN
    input  logic [3:0]  brightness,
`endif
    output logic [7:0]  an,
    output logic [7:0]  sseg,
    output logic        frame_tick,
    output logic        upd_pending
);

    localparam int                 CNT_W    = $clog2(DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DIV - 1);
    localparam digit_idx_t         IDX_LAST = digit_idx_t'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    digit_idx_t       idx_q, idx_d;
    disp_data_t       pend_q, pend_d;
    disp_data_t       act_q, act_d;
    logic             upd_q, upd_d;
    logic [7:0]       an_q, an_d;
    logic [7:0]       sseg_q, sseg_d;

    logic             slot_wrap;
    logic             frame_end;
    logic             lit;
    logic             dig_en;
    logic [7:0]       dec_seg;
    disp_data_t       wr_data;

    assign wr_data   = '{hex: hex_in, dp: dp_in, en: digit_en};
    assign slot_wrap = (cnt_q == CNT_LAST);
    assign frame_end = slot_wrap && (idx_q == IDX_LAST);

    always_comb begin
        cnt_d  = slot_wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d  = slot_wrap ? idx_q + digit_idx_t'(1) : idx_q;
        pend_d = pend_q;
        act_d  = act_q;
        upd_d  = upd_q;
        // Active data only moves on the frame boundary; a coincident write bypasses pending.
        if (frame_end) begin
            if (wr) begin
                act_d = wr_data;
            end else if (upd_q) begin
                act_d = pend_q;
            end
            upd_d = 1'b0;
        end else if (wr) begin
            pend_d = wr_data;
            upd_d  = 1'b1;
        end
    end

`ifdef SSEG_DIM_EN
    localparam int SUB   = DIV / 16;
    localparam int SUB_W = (SUB > 1) ? $clog2(SUB) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB - 1);

    // phase_q tracks cnt/(DIV/16) incrementally, avoiding a divider.
    logic [SUB_W-1:0] sub_q;
    logic [3:0]       phase_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub_q   <= '0;
            phase_q <= '0;
        end else if (slot_wrap) begin
            sub_q   <= '0;
            phase_q <= '0;
        end else if (sub_q == SUB_LAST) begin
            sub_q   <= '0;
            phase_q <= phase_q + 4'd1;
        end else begin
            sub_q   <= sub_q + SUB_W'(1);
        end
    end

    assign lit = (phase_q <= brightness);
`else
    assign lit = 1'b1;
`endif

    assign dig_en = act_q.en[idx_q];

    sseg_scan_ctrl_dec u_dec (
        .nibble (act_q.hex[idx_q*4 +: 4]),
        .dp_n   (~act_q.dp[idx_q]),
        .seg    (dec_seg)
    );

    always_comb begin
        an_d   = BLANK;
        sseg_d = BLANK;
        if (dig_en) begin
            sseg_d = dec_seg;
            if (lit) begin
                an_d = ~(8'b1 << idx_q);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            pend_q <= '0;
            act_q  <= '0;
            upd_q  <= 1'b0;
            an_q   <= BLANK;
            sseg_q <= BLANK;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            pend_q <= pend_d;
            act_q  <= act_d;
            upd_q  <= upd_d;
            an_q   <= an_d;
            sseg_q <= sseg_d;
        end
    end

    assign an          = an_q;
    assign sseg        = sseg_q;
    assign frame_tick  = frame_end;
    assign upd_pending = upd_q;

endmodule
